// File: rtl/snn_pkg.sv
// snn_pkg: shared types and constants for the spiking-neuron datapath
package snn_pkg;
   localparam int DATA_W = 32;
   typedef logic signed [DATA_W-1:0] data_t;
   typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, FIRE} state_t;
   localparam data_t SAT_MAX = 32'sh7FFF_FFFF;
   localparam data_t SAT_MIN = 32'sh8000_0000;
endpackage

// File: rtl/lif_neuron_acc_if.sv
// lif_neuron_acc_if: partial-sum input stream and neuron status/spike outputs
interface lif_neuron_acc_if;
   import snn_pkg::*;
   logic  ts_start;
   logic  mac_valid;
   data_t mac_in;
   logic  mac_last;
   logic  busy;
   logic  spike_out;
   logic  done;
   data_t v_mem;
   logic  err_overrun;
   modport master (output ts_start, mac_valid, mac_in, mac_last,
                   input  busy, spike_out, done, v_mem, err_overrun);
   modport slave  (input  ts_start, mac_valid, mac_in, mac_last,
                   output busy, spike_out, done, v_mem, err_overrun);
endinterface

// File: rtl/sat_add32.sv
// sat_add32: signed saturating adder; overflow seen as equal operand signs with a flipped result sign
module sat_add32
   import snn_pkg::*;
(
   input  data_t a,
   input  data_t b,
   output data_t y
);
   data_t s;
   assign s = a + b;
   // clamp toward the operands' sign when the wrapped sum changed sign
   always_comb begin
      y = (a[DATA_W-1] == b[DATA_W-1] && s[DATA_W-1] != a[DATA_W-1]) ? (a[DATA_W-1] ? SAT_MIN : SAT_MAX) : s;
   end
endmodule

// File: rtl/lif_neuron_acc.sv
// lif_neuron_acc: per-timestep partial-sum accumulator with leaky integrate-and-fire update
module lif_neuron_acc
   import snn_pkg::*;
#(
   parameter data_t THRESHOLD     = 1000,
   parameter int    LEAK_SHIFT    = 3,
   parameter data_t V_RESET       = 0,
   parameter int    REFRACT_STEPS = 2
)(
   input logic             CLK,
   input logic             RESET,
   lif_neuron_acc_if.slave nif
);
   localparam int RW = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
   state_t          state;
   data_t           acc;
   data_t           v_mem_r;
   logic [RW-1:0]   refract_cnt;
   logic            spike_r;
   logic            done_r;
   logic            busy_r;
   logic            err_r;
   data_t           acc_sum;
   data_t           v_leaked;
   data_t           v_sum;
   // leak never overflows: the shifted term has the same sign and no larger magnitude
   assign v_leaked = v_mem_r - (v_mem_r >>> LEAK_SHIFT);
   sat_add32 u_acc_add (.a(acc),      .b(nif.mac_in), .y(acc_sum));
   sat_add32 u_v_add   (.a(v_leaked), .b(acc),        .y(v_sum));
   assign nif.busy        = busy_r;
   assign nif.spike_out   = spike_r;
   assign nif.done        = done_r;
   assign nif.v_mem       = v_mem_r;
   assign nif.err_overrun = err_r;
   // timestep FSM: accumulate beats, integrate with leak, then test threshold and emit pulses
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         acc         <= '0;
         v_mem_r     <= V_RESET;
         refract_cnt <= '0;
         spike_r     <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         spike_r <= 1'b0;
         done_r  <= 1'b0;
         if (nif.ts_start && state != IDLE) err_r <= 1'b1;
         case (state)
            IDLE: if (nif.ts_start) begin
               acc    <= '0;
               busy_r <= 1'b1;
               state  <= ACCUM;
            end
            ACCUM: if (nif.mac_valid) begin
               acc <= acc_sum;
               if (nif.mac_last) state <= UPDATE;
            end
            UPDATE: begin
               if (refract_cnt != '0) begin
                  v_mem_r     <= V_RESET;
                  refract_cnt <= refract_cnt - RW'(1);
               end else v_mem_r <= v_sum;
               state <= FIRE;
            end
            FIRE: begin
               if (refract_cnt == '0 && v_mem_r >= THRESHOLD) begin
                  spike_r     <= 1'b1;
                  v_mem_r     <= V_RESET;
                  refract_cnt <= RW'(REFRACT_STEPS);
               end
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lif_neuron_acc.sv
// tb_lif_neuron_acc: randomized scoreboard bench against an arithmetic neuron model
module tb_lif_neuron_acc;
   typedef struct {
      bit  spike;
      int  v;
      int  cyc;
   } exp_t;
   logic CLK = 1'b0;
   logic RESET = 1'b1;
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   exp_t sb[$];
   longint macc;
   int mv;
   int mr;
   lif_neuron_acc_if nif ();
   lif_neuron_acc dut (.CLK(CLK), .RESET(RESET), .nif(nif.slave));
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask
   function automatic int clamp(input longint x);
      return (x > 64'sd2147483647) ? 32'h7FFF_FFFF : (x < -64'sd2147483648) ? 32'h8000_0000 : int'(x);
   endfunction
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic start();
      nif.ts_start  = 1'b1;
      nif.mac_valid = $urandom_range(0, 1);
      nif.mac_in    = $urandom;
      nif.mac_last  = $urandom_range(0, 1);
      macc = 0;
      tick();
      nif.ts_start  = 1'b0;
      nif.mac_valid = 1'b0;
      nif.mac_last  = 1'b0;
   endtask
   task automatic beat(input int v, input bit last);
      longint t;
      int vpre;
      bit sp;
      nif.mac_valid = 1'b1;
      nif.mac_in    = v;
      nif.mac_last  = last;
      macc = clamp(macc + v);
      if (last) begin
         if (mr > 0) begin
            mv = 0;
            mr--;
         end else begin
            t  = longint'(mv) - longint'(mv >>> 3) + macc;
            mv = clamp(t);
         end
         vpre = mv;
         sp = (mr == 0 && mv >= 1000);
         if (sp) begin
            mv = 0;
            mr = 2;
         end
         sb.push_back('{sp, mv, cyc + 3});
      end
      tick();
      nif.mac_valid = 1'b0;
      nif.mac_last  = 1'b0;
      if (last) begin
         tick();
         chk("v_mem_integrated", nif.v_mem, vpre);
         tick();
      end
   endtask
   always @(negedge CLK) begin
      if (!RESET && nif.done) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no pending timestep at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("spike_out", nif.spike_out, e.spike);
            chk("v_mem_after_done", nif.v_mem, e.v);
            chk("done_latency_cycle", cyc, e.cyc);
            chk("busy_after_done", nif.busy, 0);
         end
      end
   end
   initial begin
      nif.ts_start = 0; nif.mac_valid = 0; nif.mac_in = 0; nif.mac_last = 0;
      mv = 0; mr = 0; macc = 0;
      for (int i = 0; i < 4; i++) begin
         nif.ts_start  = $urandom_range(0, 1);
         nif.mac_valid = $urandom_range(0, 1);
         nif.mac_in    = $urandom;
         nif.mac_last  = $urandom_range(0, 1);
         tick();
      end
      chk("rst_busy", nif.busy, 0);
      chk("rst_spike", nif.spike_out, 0);
      chk("rst_done", nif.done, 0);
      chk("rst_err", nif.err_overrun, 0);
      chk("rst_v_mem", nif.v_mem, 0);
      nif.ts_start = 0; nif.mac_valid = 0; nif.mac_last = 0;
      RESET = 1'b0;
      tick();
      start(); beat(300, 0); beat(400, 1);
      start(); beat(400, 1);
      for (int i = 0; i < 3; i++) begin
         start(); beat(5000, 1);
      end
      for (int i = 0; i < 2; i++) begin
         start(); beat(0, 1);
      end
      start(); beat(32'h7FFF_FFF0, 0); beat(32'h0000_0100, 1);
      start(); beat(-32'sd2000000000, 0); beat(-32'sd2000000000, 1);
      for (int i = 0; i < 30; i++) begin
         int n;
         n = $urandom_range(1, 4);
         start();
         for (int j = 0; j < n; j++) begin
            int v;
            v = ($urandom_range(0, 9) == 0) ? int'($urandom) : $urandom_range(0, 1500) - 600;
            if ($urandom_range(0, 3) == 0) tick();
            beat(v, j == n - 1);
         end
      end
      start(); beat(100, 0);
      nif.ts_start = 1'b1;
      tick();
      nif.ts_start = 1'b0;
      chk("err_overrun_set", nif.err_overrun, 1);
      beat(200, 1);
      start(); beat(50, 1);
      chk("err_overrun_sticky", nif.err_overrun, 1);
      start(); beat(123, 0);
      RESET = 1'b1;
      #1;
      mv = 0; mr = 0;
      chk("midreset_busy", nif.busy, 0);
      chk("midreset_v_mem", nif.v_mem, 0);
      chk("midreset_err", nif.err_overrun, 0);
      tick();
      RESET = 1'b0;
      repeat (5) tick();
      start(); beat(700, 1);
      start(); beat(500, 1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
